pacman_palette: RTL
===================

# pacman_palette

Palette stage directly downstream of the 32-bit color PIO output word. It decodes command words that software writes through that PIO and commits each one into a 16-entry RGB888 palette. Commits are deferred to vertical blanking so a frame never shows a half-updated palette. It also serves pixel-index lookups from the VGA sprite/tile path with a fixed 2-cycle latency.

## Interface
- DEFER_TO_VBLANK, 1, 1: commits wait for vblank=1; 0: commit on the cycle after capture.
- clk  in  1  system clock; the PIO, this block and the pixel path share it.
- reset_n  in  1  reset, asynchronous, active-low.
- color_word  in  32  PIO output word. [31] cmd toggle, [30:28] reserved (ignored), [27:24] palette index, [23:0] RGB888.
- vblank  in  1  vertical blanking, level, synchronous to clk.
- pix_valid  in  1  lookup request qualifier.
- pix_index  in  4  palette index to look up.
- pix_rgb  out  24  looked-up colour; 0 when the corresponding request had pix_valid=0.
- pix_rgb_valid  out  1  pix_valid delayed 2 cycles.
- ack_toggle  out  1  equals cmd toggle of the last committed command; software polls it through a PIO input.
- busy  out  1  1 while a captured command awaits commit.

## Operation
- Registers:
  - last_toggle (reset 0).
  - pend_idx[3:0], pend_rgb[23:0], pend_toggle.
  - palette: 16x24 flops, all reset to 24'h000000.
  - FSM state.
- FSM states: IDLE (reset), PENDING.
- IDLE: if color_word[31] != last_toggle, capture idx/rgb/toggle into pend_*, set last_toggle=color_word[31], go to PENDING. Otherwise stay.
- PENDING: commit condition is DEFER_TO_VBLANK=0, or vblank=1. On commit:
  - palette[pend_idx] <= pend_rgb
  - ack_toggle <= pend_toggle
  - go to IDLE
  - Otherwise hold.
- Toggle changes while PENDING are not captured then. After return to IDLE, a still-differing toggle is captured on the next IDLE cycle. No command is lost while the toggle level differs; a toggle flipped twice during PENDING is invisible, by design. Software protocol: wait for ack_toggle == toggle before the next write.
- Changes to color_word[27:0] without a toggle change are ignored.
- busy = (state == PENDING), combinational from state.
- Lookup pipeline:
  - Stage 1 registers pix_valid and pix_index.
  - Stage 2 registers pix_rgb = s1_valid ? palette[s1_index] : 0, and pix_rgb_valid = s1_valid.
  - The lookup pipeline never stalls.
- Reset mid-operation: any pending command is discarded. Palette, ack_toggle, last_toggle and pipeline are cleared immediately (async). After reset, a color_word with [31]=1 is seen as a new command.

## Timing
- Capture: toggle differs in IDLE at cycle N; state=PENDING and busy=1 from N+1.
- Commit, DEFER_TO_VBLANK=0: the palette write and ack_toggle update are visible at N+2; busy=0 at N+2.
- Commit, deferred: the first cycle M≥N+1 with vblank=1 in PENDING is the commit cycle; palette, ack_toggle and busy=0 are visible at M+1.
- Minimum command period: 2 cycles (IDLE→PENDING→IDLE).
- Lookup latency: request at cycle N, result at N+2.
- Lookup vs commit: stage 2 reads the palette value present before the edge. A lookup whose stage-2 register loads on the commit edge returns the old colour; the following one returns the new colour.
- Reset values: pix_rgb=0, pix_rgb_valid=0, ack_toggle=0, busy=0.

## Test plan
- Reset, then pix_valid=1, pix_index=5 at cycle N → pix_rgb=24'h000000 with pix_rgb_valid=1 at N+2; ack_toggle=0, busy=0.
- DEFER=0, color_word=32'h8_3_FF8800 (toggle 1, idx 3) → busy=1 for exactly one cycle and ack_toggle=1; a lookup of idx 3 two cycles later returns 24'hFF8800.
- DEFER=1, vblank=0, toggle flips with idx 7 rgb 24'h00FF00 → busy stays 1 and lookups of idx 7 return 0 for 50 cycles. Raise vblank → commit next cycle, ack matches, lookups return 24'h00FF00.
- While PENDING, software changes [23:0] without a toggle flip → the committed value is the captured one. Flip the toggle during PENDING → the second command commits after the first, ack_toggle follows both.
- Assert reset_n low mid-PENDING → busy=0, ack_toggle=0, palette all 0. After release, color_word with [31]=1 is captured as a new command.
- Back-to-back lookups of idx 2 spanning the commit edge of rgb 24'h123456 → old value up to and including the commit-edge result, 24'h123456 afterwards, with no bubbles in pix_rgb_valid.

Source files
------------

// File: rtl/pacman_palette.sv
// pacman_palette: decodes toggle-qualified command words from the colour PIO,
// commits them into a 16-entry RGB888 palette (optionally deferred to
// vertical blanking), and serves pixel-index lookups with a fixed 2-cycle
// latency.
module pacman_palette #(
    parameter bit DEFER_TO_VBLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] color_word,
    input  logic        vblank,
    input  logic        pix_valid,
    input  logic [3:0]  pix_index,
    output logic [23:0] pix_rgb,
    output logic        pix_rgb_valid,
    output logic        ack_toggle,
    output logic        busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Command word fields.
    logic        cmd_toggle;
    logic [3:0]  cmd_idx;
    logic [23:0] cmd_rgb;

    assign cmd_toggle = color_word[31];
    assign cmd_idx    = color_word[27:24];
    assign cmd_rgb    = color_word[23:0];

    // Reserved command bits carry no meaning for this block.
    logic unused_reserved;
    assign unused_reserved = ^color_word[30:28];

    logic        last_toggle;
    logic [3:0]  pend_idx;
    logic [23:0] pend_rgb;
    logic        pend_toggle;
    logic [23:0] palette [16];

    logic        capture;
    logic        commit;

    logic        s1_valid;
    logic [3:0]  s1_index;

    assign busy = (state == PENDING);

    // State register for the command FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of block ordering.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: capture a new command in IDLE, commit it from PENDING.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_toggle != last_toggle) begin
                    capture    = 1'b1;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (!DEFER_TO_VBLANK || vblank) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the command fields and the toggle level when a command is captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_toggle <= 1'b0;
            pend_idx    <= '0;
            pend_rgb    <= '0;
            pend_toggle <= 1'b0;
        end else if (capture) begin
            last_toggle <= cmd_toggle;
            pend_idx    <= cmd_idx;
            pend_rgb    <= cmd_rgb;
            pend_toggle <= cmd_toggle;
        end
    end

    // Palette write and acknowledge on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the palette is built from flops rather than a RAM because a
        // reset must blank every entry at once; RAM macros cannot be reset.
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= '0;
            end
            ack_toggle <= 1'b0;
        end else if (commit) begin
            palette[pend_idx] <= pend_rgb;
            ack_toggle        <= pend_toggle;
        end
    end

    // Lookup stage 1: register the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_index <= pix_index;
        end
    end

    // Lookup stage 2: read the palette as it stood before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_rgb       <= '0;
            pix_rgb_valid <= 1'b0;
        end else begin
            pix_rgb       <= s1_valid ? palette[s1_index] : 24'h000000;
            pix_rgb_valid <= s1_valid;
        end
    end

endmodule
